// File: rtl/arm_balance_n.sv
// Capacitor-voltage balancing selector for one arm of N full-bridge cells.
// Optional hysteresis bias on the sort keys is enabled by defining ARM_BAL_HYST_EN.
module arm_balance_n #(
    parameter int N_CELLS = 4,
    parameter int VW      = 8,
    parameter int LW      = 4,
    parameter int HYST    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    period_flag,
    input  logic                    signI,
    input  logic [LW-1:0]           vc_level,
    input  logic [N_CELLS*VW-1:0]   vc,
    output logic [2*N_CELLS-1:0]    Fo,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    typedef enum logic [1:0] {IDLE, SEL, COMMIT} state_t;

    state_t                 r_state, w_next;
    logic [N_CELLS*VW-1:0]  r_vc;
    logic                   r_pol_neg, r_dis;
    logic                   r_hold;
    logic [LW-1:0]          r_cnt;
    logic [N_CELLS-1:0]     r_mask;
    logic [2*N_CELLS-1:0]   r_prev, r_fo, w_code;
    logic                   r_done, r_ovr;

    logic signed [LW:0]     w_d;
    logic [LW-1:0]          w_k;
    logic                   w_neg, w_hold, w_dis;
    logic [N_CELLS-1:0]     w_bias, w_win_oh;
    logic [VW:0]            w_key, w_best;
    logic                   w_found;

    // Search key: raw voltage, optionally biased toward cells already inserted with the same polarity.
    function automatic logic [VW:0] bal_key(input logic [VW-1:0] v, input logic bias, input logic dis);
        logic [VW+1:0] up;
        logic [VW:0]   k;
        k  = {1'b0, v};
        up = {2'b00, v} + (VW+2)'(HYST);
        if (bias) begin
            if (dis)
                k = up[VW+1] ? '1 : up[VW:0];
            else
                k = (v >= VW'(HYST)) ? {1'b0, v - VW'(HYST)} : '0;
        end
        return k;
    endfunction

    always_comb begin
        w_d    = $signed({1'b0, vc_level}) - $signed((LW+1)'(N_CELLS));
        w_neg  = w_d[LW];
        w_k    = w_neg ? LW'(-w_d) : LW'(w_d);
        w_hold = (vc_level > LW'(2*N_CELLS));
        w_dis  = (signI == 1'b0) ^ w_neg;
    end

`ifdef ARM_BAL_HYST_EN
    always_comb begin
        w_bias = '0;
        for (int i = 0; i < N_CELLS; i++)
            w_bias[i] = (r_prev[2*i +: 2] == (r_pol_neg ? 2'b01 : 2'b10));
    end
`else
    assign w_bias = '0;
`endif

    // One winner per cycle among unselected cells; strict compare keeps ties on the lowest index.
    always_comb begin
        w_found  = 1'b0;
        w_win_oh = '0;
        w_best   = '0;
        w_key    = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            w_key = bal_key(r_vc[i*VW +: VW], w_bias[i], r_dis);
            if (!r_mask[i] && (!w_found || (r_dis ? (w_key > w_best) : (w_key < w_best)))) begin
                w_found     = 1'b1;
                w_best      = w_key;
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_code = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (r_mask[i])
                w_code[2*i +: 2] = r_pol_neg ? 2'b01 : 2'b10;
            else
                w_code[2*i +: 2] = (r_prev[2*i +: 2] == 2'b11) ? 2'b11 : 2'b00;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (period_flag) w_next = (w_hold || w_k == '0) ? COMMIT : SEL;
            SEL:     if (r_cnt == LW'(1)) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Snapshot of voltages and steering; only meaningful while a selection is running.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && period_flag) begin
            r_vc      <= vc;
            r_pol_neg <= w_neg;
            r_dis     <= w_dis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 1'b0;
            r_cnt  <= '0;
            r_mask <= '0;
            r_prev <= '0;
            r_fo   <= '0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (period_flag && r_state != IDLE)
                r_ovr <= 1'b1;
            case (r_state)
                IDLE: if (period_flag) begin
                    r_hold <= w_hold;
                    r_cnt  <= w_k;
                    r_mask <= '0;
                end
                SEL: begin
                    r_mask <= r_mask | w_win_oh;
                    r_cnt  <= r_cnt - LW'(1);
                end
                COMMIT: begin
                    r_done <= 1'b1;
                    if (!r_hold) begin
                        r_fo   <= w_code;
                        r_prev <= w_code;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Fo      = r_fo;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign overrun = r_ovr;

endmodule

// File: tb/tb_arm_balance_n.sv
// Directed bench for arm_balance_n (N_CELLS=4, VW=8, LW=4, HYST=4).
module tb_arm_balance_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        period_flag;
    logic        signI;
    logic [3:0]  vc_level;
    logic [31:0] vc;
    logic [7:0]  Fo;
    logic        busy, done, overrun;

    int checks = 0;
    int errors = 0;

    arm_balance_n #(.N_CELLS(4), .VW(8), .LW(4), .HYST(4)) dut (
        .clk(clk), .rst(rst), .period_flag(period_flag), .signI(signI),
        .vc_level(vc_level), .vc(vc), .Fo(Fo), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  lvl;
        logic        sgn;
        logic [31:0] vcv;
        logic [7:0]  fo;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] lvl, input logic sgn, input logic [31:0] v);
        @(negedge clk);
        vc_level    = lvl;
        signI       = sgn;
        vc          = v;
        period_flag = 1'b1;
        @(negedge clk);
        period_flag = 1'b0;
    endtask

    // Waits for done, counting cycles after the strobe edge, and checks Fo never moves early.
    task automatic wait_done(input string name, input logic [7:0] fo_before, output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            if (Fo !== fo_before) check({name, " early Fo"}, Fo, fo_before);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_case(input string name, input vec_t t);
        logic [7:0] fo0;
        int lat;
        fo0 = Fo;
        strobe(t.lvl, t.sgn, t.vcv);
        check({name, " busy"}, busy, 1'b1);
        wait_done(name, fo0, lat);
        check({name, " latency"}, lat, t.lat);
        check({name, " Fo"}, Fo, t.fo);
        check({name, " busy at done"}, busy, 1'b0);
        @(negedge clk);
        check({name, " done pulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        logic [31:0] v0;
        v0 = {8'd50, 8'd90, 8'd70, 8'd90};
        tbl[0]  = '{4'd4,  1'b0, v0, 8'b00_00_00_00, 1};
        tbl[1]  = '{4'd6,  1'b0, v0, 8'b00_10_00_10, 3};
        tbl[2]  = '{4'd1,  1'b0, v0, 8'b01_00_01_01, 4};
        tbl[3]  = '{4'd9,  1'b0, v0, 8'b01_00_01_01, 1};
        tbl[4]  = '{4'd8,  1'b1, v0, 8'b10_10_10_10, 5};
        tbl[5]  = '{4'd0,  1'b1, v0, 8'b01_01_01_01, 5};
        tbl[6]  = '{4'd5,  1'b1, v0, 8'b10_00_00_00, 2};
        tbl[7]  = '{4'd3,  1'b1, v0, 8'b00_00_00_01, 2};
        tbl[8]  = '{4'd2,  1'b0, {8'd10, 8'd20, 8'd30, 8'd40}, 8'b01_01_00_00, 3};
        tbl[9]  = '{4'd15, 1'b0, v0, 8'b01_01_00_00, 1};
        tbl[10] = '{4'd7,  1'b0, {4{8'd255}}, 8'b00_10_10_10, 4};
        tbl[11] = '{4'd7,  1'b0, {4{8'd0}},   8'b00_10_10_10, 4};

        rst = 1'b1; period_flag = 1'b0; signI = 1'b0; vc_level = '0; vc = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset Fo", Fo, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset overrun", overrun, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_case($sformatf("vec%0d", i), tbl[i]);
            check($sformatf("vec%0d overrun", i), overrun, 1'b0);
        end

        // Second strobe during a K=3 selection is ignored but flagged.
        strobe(4'd1, 1'b0, v0);
        @(negedge clk);
        vc_level = 4'd8; signI = 1'b1; vc = '0; period_flag = 1'b1;
        @(negedge clk);
        period_flag = 1'b0;
        check("ovr set", overrun, 1'b1);
        lat = 2;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ovr latency", lat, 4);
        check("ovr Fo", Fo, 8'b01_00_01_01);
        repeat (3) @(negedge clk);
        check("ovr sticky", overrun, 1'b1);

        // Asynchronous reset in the middle of a selection.
        strobe(4'd1, 1'b0, v0);
        rst = 1'b1;
        #1;
        check("rst Fo", Fo, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst overrun", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) lat++;
        end
        check("rst no done", lat, 0);

        // Hysteresis: cell0 inserted at 88 competes against cell1 at 90.
        run_case("hyst seed", '{4'd5, 1'b0, {8'd10, 8'd10, 8'd10, 8'd100}, 8'b00_00_00_10, 2});
`ifdef ARM_BAL_HYST_EN
        run_case("hyst pick", '{4'd5, 1'b0, {8'd10, 8'd10, 8'd90, 8'd88}, 8'b00_00_00_10, 2});
`else
        run_case("hyst pick", '{4'd5, 1'b0, {8'd10, 8'd10, 8'd90, 8'd88}, 8'b00_00_10_00, 2});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
